// File: rtl/dmem_access_unit_pkg.sv
// dmem_access_unit_pkg: funct3 size/sign encodings and FSM state type for the data-memory access unit.
package dmem_access_unit_pkg;
  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;
  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;
  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;
endpackage

// File: rtl/dmem_access_unit_lane_align.sv
// dmem_access_unit_lane_align: store strobe/data lane replication, load extract and extend, misalign check.
module dmem_access_unit_lane_align
  import dmem_access_unit_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NB   = XLEN / 8,
  parameter int OW   = $clog2(NB)
) (
  input  logic [2:0]      funct3,
  input  logic [OW-1:0]   offset,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata,
  output logic [NB-1:0]   wstrb,
  output logic [XLEN-1:0] wdata_rep,
  output logic [XLEN-1:0] load_data,
  output logic            misaligned
);
  logic [1:0]      size;
  logic [7:0]      mask;
  logic [XLEN-1:0] sh;
  assign size = funct3[1:0];
  assign mask = size == SZ_B ? 8'h01 : size == SZ_H ? 8'h03 : size == SZ_W ? 8'h0F : 8'hFF;
  assign wstrb = NB'(mask) << offset;
  assign wdata_rep = size == SZ_B ? {NB{wdata[7:0]}} :
                     size == SZ_H ? {(NB/2){wdata[15:0]}} :
                     size == SZ_W ? {(NB/4){wdata[31:0]}} : wdata;
  assign misaligned = (size == SZ_H && offset[0]) || (size == SZ_W && |offset[1:0]) ||
                      (size == SZ_D && |offset);
  // Selected lane ends up in the low bits before extension.
  assign sh = rdata >> {offset, 3'b000};
  assign load_data = funct3 == F3_B  ? XLEN'($signed(sh[7:0])) :
                     funct3 == F3_BU ? XLEN'(sh[7:0]) :
                     funct3 == F3_H  ? XLEN'($signed(sh[15:0])) :
                     funct3 == F3_HU ? XLEN'(sh[15:0]) :
                     funct3 == F3_W  ? XLEN'($signed(sh[31:0])) :
                     funct3 == F3_WU ? XLEN'(sh[31:0]) : sh;
endmodule

// File: rtl/dmem_access_unit.sv
// dmem_access_unit: MEM-stage load/store to valid/ready data bus bridge with pipeline hold.
// Define DMEM_TIMEOUT_EN to abort stuck bus accesses after TIMEOUT_CYCLES with a fault.
module dmem_access_unit
  import dmem_access_unit_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              valid_in,
  input  logic              mem_read_in,
  input  logic              mem_write_in,
  input  logic [XLEN-1:0]   addr_in,
  input  logic [XLEN-1:0]   wdata_in,
  input  logic [2:0]        funct3_in,
  input  logic              flush_in,
  input  logic              stall_in,
  output logic              hold_out,
  output logic              access_done_out,
  output logic [XLEN-1:0]   load_data_out,
  output logic              access_fault_out,
  output logic              misaligned_out,
  output logic              dbus_req_valid,
  input  logic              dbus_req_ready,
  output logic [XLEN-1:0]   dbus_req_addr,
  output logic              dbus_req_we,
  output logic [XLEN-1:0]   dbus_req_wdata,
  output logic [XLEN/8-1:0] dbus_req_wstrb,
  input  logic              dbus_resp_valid,
  input  logic [XLEN-1:0]   dbus_resp_rdata,
  input  logic              dbus_resp_err
);
  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);
  state_t          state, nxt;
  logic            kill, kill_now, qualify, timeout, resp_taken, busy;
  logic [XLEN-1:0] addr_q, ldata_q, al_wdata, al_ldata;
  logic [2:0]      f3_q, al_f3;
  logic [OW-1:0]   al_off;
  logic [NB-1:0]   al_strb;
  logic            al_mis, fault_q;
  // Formatter sees the incoming instruction while idle and the captured one afterwards.
  assign al_f3  = state == IDLE ? funct3_in : f3_q;
  assign al_off = state == IDLE ? addr_in[OW-1:0] : addr_q[OW-1:0];
  dmem_access_unit_lane_align #(.XLEN(XLEN)) u_align (
    .funct3(al_f3), .offset(al_off), .wdata(wdata_in), .rdata(dbus_resp_rdata),
    .wstrb(al_strb), .wdata_rep(al_wdata), .load_data(al_ldata), .misaligned(al_mis)
  );
  assign busy       = state == REQ || state == RESP;
  assign qualify    = valid_in && (mem_read_in || mem_write_in) && !al_mis && !flush_in;
  assign kill_now   = kill || flush_in;
  assign resp_taken = state == RESP && dbus_resp_valid;
`ifdef DMEM_TIMEOUT_EN
  localparam int CW = TIMEOUT_CYCLES > 255 ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CW-1:0] cnt;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) cnt <= '0;
    else if (state == IDLE) cnt <= '0;
    else if (busy) cnt <= cnt + 1'b1;
  assign timeout = busy && cnt == CW'(TIMEOUT_CYCLES - 1);
`else
  assign timeout = 1'b0;
`endif
  always_comb begin
    nxt = state;
    hold_out = 1'b0;
    dbus_req_valid = 1'b0;
    case (state)
      IDLE: begin
        hold_out = qualify;
        nxt = qualify ? REQ : IDLE;
      end
      REQ: begin
        hold_out = 1'b1;
        dbus_req_valid = 1'b1;
        nxt = dbus_req_ready ? RESP : timeout ? (kill_now ? IDLE : DONE) : REQ;
      end
      RESP: begin
        hold_out = 1'b1;
        nxt = (dbus_resp_valid || timeout) ? (kill_now ? IDLE : DONE) : RESP;
      end
      default: nxt = (stall_in && !flush_in) ? DONE : IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state          <= IDLE;
      kill           <= 1'b0;
      addr_q         <= '0;
      f3_q           <= '0;
      dbus_req_we    <= 1'b0;
      dbus_req_wdata <= '0;
      dbus_req_wstrb <= '0;
      ldata_q        <= '0;
      fault_q        <= 1'b0;
    end else begin
      state <= nxt;
      kill  <= busy && (nxt == REQ || nxt == RESP) && kill_now;
      if (state == IDLE && qualify) begin
        addr_q         <= addr_in;
        f3_q           <= funct3_in;
        dbus_req_we    <= mem_write_in;
        dbus_req_wdata <= al_wdata;
        dbus_req_wstrb <= al_strb;
      end
      if (busy && nxt == DONE) begin
        ldata_q <= resp_taken ? al_ldata : '0;
        fault_q <= resp_taken ? dbus_resp_err : 1'b1;
      end
    end
  assign dbus_req_addr    = {addr_q[XLEN-1:OW], OW'(0)};
  assign access_done_out  = state == DONE;
  assign load_data_out    = access_done_out ? ldata_q : '0;
  assign access_fault_out = access_done_out && fault_q;
  assign misaligned_out   = state == IDLE && valid_in && (mem_read_in || mem_write_in) && al_mis;
endmodule

// File: tb/tb_dmem_access_unit.sv
// tb_dmem_access_unit: table-driven and directed sequence checks of dmem_access_unit (XLEN=32).
module tb_dmem_access_unit;
  logic        clk = 0, reset_n = 0;
  logic        valid_in = 0, mem_read_in = 0, mem_write_in = 0, flush_in = 0, stall_in = 0;
  logic [31:0] addr_in = 0, wdata_in = 0;
  logic [2:0]  funct3_in = 0;
  logic        hold_out, access_done_out, access_fault_out, misaligned_out;
  logic [31:0] load_data_out;
  logic        dbus_req_valid, dbus_req_ready = 0, dbus_req_we;
  logic [31:0] dbus_req_addr, dbus_req_wdata;
  logic [3:0]  dbus_req_wstrb;
  logic        dbus_resp_valid = 0, dbus_resp_err = 0;
  logic [31:0] dbus_resp_rdata = 0;
  int checks = 0, errors = 0;

  dmem_access_unit #(.XLEN(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset_n(reset_n), .valid_in(valid_in), .mem_read_in(mem_read_in),
    .mem_write_in(mem_write_in), .addr_in(addr_in), .wdata_in(wdata_in), .funct3_in(funct3_in),
    .flush_in(flush_in), .stall_in(stall_in), .hold_out(hold_out),
    .access_done_out(access_done_out), .load_data_out(load_data_out),
    .access_fault_out(access_fault_out), .misaligned_out(misaligned_out),
    .dbus_req_valid(dbus_req_valid), .dbus_req_ready(dbus_req_ready),
    .dbus_req_addr(dbus_req_addr), .dbus_req_we(dbus_req_we), .dbus_req_wdata(dbus_req_wdata),
    .dbus_req_wstrb(dbus_req_wstrb), .dbus_resp_valid(dbus_resp_valid),
    .dbus_resp_rdata(dbus_resp_rdata), .dbus_resp_err(dbus_resp_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end, got timeout required finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [2:0]  f3;
    logic        we;
    logic [31:0] addr, wdata, rdata;
    logic        err, mis;
    logic [3:0]  strb;
    logic [31:0] xw, xl;
  } vec_t;
  vec_t vecs[13];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    valid_in = 0; mem_read_in = 0; mem_write_in = 0; flush_in = 0; stall_in = 0;
    dbus_req_ready = 0; dbus_resp_valid = 0; dbus_resp_err = 0;
  endtask

  task automatic issue(input logic [2:0] f3, input logic we, input logic [31:0] a, input logic [31:0] d);
    valid_in = 1; mem_read_in = !we; mem_write_in = we; funct3_in = f3; addr_in = a; wdata_in = d;
  endtask

  task automatic run_vec(input vec_t v, input int n);
    @(negedge clk); issue(v.f3, v.we, v.addr, v.wdata);
    #1;
    check($sformatf("v%0d misaligned", n), misaligned_out, v.mis);
    check($sformatf("v%0d accept hold", n), hold_out, !v.mis);
    @(negedge clk); idle_inputs();
    if (v.mis) begin
      #1;
      check($sformatf("v%0d mis no req", n), dbus_req_valid, 0);
      check($sformatf("v%0d mis no hold", n), hold_out, 0);
      return;
    end
    dbus_req_ready = 1;
    #1;
    check($sformatf("v%0d req_valid", n), dbus_req_valid, 1);
    check($sformatf("v%0d req_addr", n), dbus_req_addr, v.addr & 32'hFFFF_FFFC);
    check($sformatf("v%0d req_we", n), dbus_req_we, v.we);
    check($sformatf("v%0d wstrb", n), dbus_req_wstrb, v.strb);
    check($sformatf("v%0d wdata", n), dbus_req_wdata, v.xw);
    check($sformatf("v%0d req hold", n), hold_out, 1);
    @(negedge clk); dbus_req_ready = 0; dbus_resp_valid = 1; dbus_resp_rdata = v.rdata; dbus_resp_err = v.err;
    #1;
    check($sformatf("v%0d resp hold", n), hold_out, 1);
    check($sformatf("v%0d resp no req", n), dbus_req_valid, 0);
    @(negedge clk); dbus_resp_valid = 0; dbus_resp_err = 0;
    #1;
    check($sformatf("v%0d done", n), access_done_out, 1);
    check($sformatf("v%0d load_data", n), load_data_out, v.xl);
    check($sformatf("v%0d fault", n), access_fault_out, v.err);
    check($sformatf("v%0d done hold", n), hold_out, 0);
    @(negedge clk); #1;
    check($sformatf("v%0d back idle", n), access_done_out, 0);
  endtask

  initial begin
    vecs[0]  = '{3'b010, 0, 32'h1004, 32'h0, 32'hDEADBEEF, 0, 0, 4'hF, 32'h0, 32'hDEADBEEF};
    vecs[1]  = '{3'b000, 0, 32'h1003, 32'h0, 32'h80112233, 0, 0, 4'h8, 32'h0, 32'hFFFFFF80};
    vecs[2]  = '{3'b100, 0, 32'h1003, 32'h0, 32'h80112233, 0, 0, 4'h8, 32'h0, 32'h00000080};
    vecs[3]  = '{3'b001, 1, 32'h2002, 32'h0000ABCD, 32'h0, 0, 0, 4'hC, 32'hABCDABCD, 32'h0};
    vecs[4]  = '{3'b001, 0, 32'h1001, 32'h0, 32'h0, 0, 1, 4'h0, 32'h0, 32'h0};
    vecs[5]  = '{3'b001, 0, 32'h1002, 32'h0, 32'h80010000, 0, 0, 4'hC, 32'h0, 32'hFFFF8001};
    vecs[6]  = '{3'b101, 0, 32'h1002, 32'h0, 32'h80010000, 0, 0, 4'hC, 32'h0, 32'h00008001};
    vecs[7]  = '{3'b000, 1, 32'h3001, 32'h12345678, 32'h0, 0, 0, 4'h2, 32'h78787878, 32'h0};
    vecs[8]  = '{3'b010, 1, 32'h3000, 32'hCAFEF00D, 32'h0, 0, 0, 4'hF, 32'hCAFEF00D, 32'h0};
    vecs[9]  = '{3'b010, 0, 32'h1002, 32'h0, 32'h0, 0, 1, 4'h0, 32'h0, 32'h0};
    vecs[10] = '{3'b010, 1, 32'h1001, 32'h0, 32'h0, 0, 1, 4'h0, 32'h0, 32'h0};
    vecs[11] = '{3'b000, 0, 32'h1001, 32'h0, 32'h00007F00, 0, 0, 4'h2, 32'h0, 32'h0000007F};
    vecs[12] = '{3'b010, 0, 32'h1000, 32'h0, 32'h12345678, 1, 0, 4'hF, 32'h0, 32'h12345678};

    repeat (2) @(negedge clk);
    #1;
    check("reset done", access_done_out, 0);
    check("reset hold", hold_out, 0);
    check("reset req_valid", dbus_req_valid, 0);
    check("reset load", load_data_out, 0);
    check("reset fault", access_fault_out, 0);
    check("reset wstrb", dbus_req_wstrb, 0);
    @(negedge clk); reset_n = 1;

    for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

    // Ready held off three cycles, flush while waiting for the response, errored response.
    @(negedge clk); issue(3'b010, 0, 32'h1008, 32'h0);
    @(negedge clk); idle_inputs();
    for (int i = 0; i < 3; i++) begin
      #1; check("slow req_valid", dbus_req_valid, 1);
      @(negedge clk);
    end
    dbus_req_ready = 1;
    @(negedge clk); dbus_req_ready = 0; flush_in = 1;
    #1; check("flush resp hold", hold_out, 1);
    @(negedge clk); flush_in = 0;
    #1; check("killed still waits", hold_out, 1);
    @(negedge clk); dbus_resp_valid = 1; dbus_resp_err = 1; dbus_resp_rdata = 32'h55555555;
    @(negedge clk); idle_inputs();
    #1;
    check("killed no done", access_done_out, 0);
    check("killed no fault", access_fault_out, 0);
    check("killed hold", hold_out, 0);
    check("killed no req", dbus_req_valid, 0);

    // Stall keeps DONE stable; flush in DONE returns to IDLE.
    @(negedge clk); issue(3'b100, 0, 32'h1003, 32'h0);
    @(negedge clk); idle_inputs(); dbus_req_ready = 1;
    @(negedge clk); dbus_req_ready = 0; dbus_resp_valid = 1; dbus_resp_rdata = 32'h80112233;
    @(negedge clk); dbus_resp_valid = 0; stall_in = 1;
    for (int i = 0; i < 2; i++) begin
      #1;
      check("stall done", access_done_out, 1);
      check("stall load", load_data_out, 32'h80);
      check("stall hold", hold_out, 0);
      @(negedge clk);
    end
    flush_in = 1;
    @(negedge clk); idle_inputs();
    #1; check("flush in done", access_done_out, 0);

    // Asynchronous reset during RESP, then a stray response in IDLE.
    @(negedge clk); issue(3'b001, 1, 32'h2002, 32'h0000ABCD);
    @(negedge clk); idle_inputs(); dbus_req_ready = 1;
    @(negedge clk); dbus_req_ready = 0;
    #2; reset_n = 0;
    #1;
    check("rst hold", hold_out, 0);
    check("rst req_valid", dbus_req_valid, 0);
    check("rst we", dbus_req_we, 0);
    check("rst wstrb", dbus_req_wstrb, 0);
    check("rst wdata", dbus_req_wdata, 0);
    check("rst addr", dbus_req_addr, 0);
    check("rst done", access_done_out, 0);
    @(negedge clk); reset_n = 1; dbus_resp_valid = 1; dbus_resp_rdata = 32'h1234;
    @(negedge clk); dbus_resp_valid = 0;
    #1;
    check("stray done", access_done_out, 0);
    check("stray hold", hold_out, 0);

`ifdef DMEM_TIMEOUT_EN
    @(negedge clk); issue(3'b010, 0, 32'h1004, 32'h0);
    @(negedge clk); idle_inputs();
    for (int i = 0; i < 4; i++) begin
      #1; check("to req_valid", dbus_req_valid, 1);
      check("to no done", access_done_out, 0);
      @(negedge clk);
    end
    #1;
    check("to done", access_done_out, 1);
    check("to fault", access_fault_out, 1);
    check("to load", load_data_out, 0);
    check("to req drop", dbus_req_valid, 0);
    @(negedge clk); dbus_resp_valid = 1; dbus_resp_rdata = 32'hFFFF;
    @(negedge clk); dbus_resp_valid = 0;
    #1;
    check("to stray done", access_done_out, 0);
    check("to stray hold", hold_out, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
